// File: rtl/inst_queue.sv
// Instruction queue between fetcher and decoder: circular FIFO of (inst, pc), one issue per cycle.
// Optional same-cycle bypass into an empty queue when INSTQUEUE_BYPASS_EN is defined.
module inst_queue #(
    parameter int QUEUE_SIZE = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_flush_in,
    input  logic        fetcher_en_in,
    input  logic [31:0] fetcher_inst_in,
    input  logic [31:0] fetcher_pc_in,
    output logic        fetcher_full_out,
    input  logic        rob_full_in,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    output logic        decoder_inst_en_out,
    output logic [31:0] decoder_inst_out,
    output logic [31:0] decoder_pc_out
);

    localparam int AW = $clog2(QUEUE_SIZE);
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(QUEUE_SIZE);
    localparam logic [AW:0] ALMOST_CNT = (AW+1)'(QUEUE_SIZE - 2);

    if (QUEUE_SIZE < 4 || (QUEUE_SIZE & (QUEUE_SIZE - 1)) != 0) begin : g_bad_size
        $error("inst_queue: QUEUE_SIZE must be a power of two and at least 4");
    end

    logic [31:0]   inst_mem [QUEUE_SIZE];
    logic [31:0]   pc_mem   [QUEUE_SIZE];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic stall;
    logic push;
    logic pop;
    logic bypass;
    logic store;

    always_comb begin
        stall  = rob_full_in | rs_full_in | lsb_full_in;
        push   = rdy_in & ~rob_flush_in & fetcher_en_in & (count != FULL_CNT);
        pop    = rdy_in & ~rob_flush_in & (count != '0) & ~stall;
`ifdef INSTQUEUE_BYPASS_EN
        bypass = push & (count == '0) & ~stall;
`else
        bypass = 1'b0;
`endif
        store  = push & ~bypass;
    end

    assign fetcher_full_out = (count >= ALMOST_CNT);

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && store) begin
            inst_mem[tail] <= fetcher_inst_in;
            pc_mem[tail]   <= fetcher_pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            decoder_inst_en_out <= 1'b0;
            decoder_inst_out    <= '0;
            decoder_pc_out      <= '0;
        end else if (rdy_in) begin
            if (rob_flush_in) begin
                head                <= '0;
                tail                <= '0;
                count               <= '0;
                decoder_inst_en_out <= 1'b0;
            end else begin
                if (store) begin
                    tail <= tail + AW'(1);
                end
                if (bypass) begin
                    decoder_inst_out    <= fetcher_inst_in;
                    decoder_pc_out      <= fetcher_pc_in;
                    decoder_inst_en_out <= 1'b1;
                end else if (pop) begin
                    decoder_inst_out    <= inst_mem[head];
                    decoder_pc_out      <= pc_mem[head];
                    decoder_inst_en_out <= 1'b1;
                    head                <= head + AW'(1);
                end else begin
                    decoder_inst_en_out <= 1'b0;
                end
                case ({store, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue: a queue-based reference model feeds an
// expected-issue scoreboard that a negedge monitor drains and compares against the DUT.
module tb_inst_queue;

    localparam int QS = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        rob_flush_in = 1'b0;
    logic        fetcher_en_in = 1'b0;
    logic [31:0] fetcher_inst_in = '0;
    logic [31:0] fetcher_pc_in = '0;
    logic        fetcher_full_out;
    logic        rob_full_in = 1'b0;
    logic        rs_full_in = 1'b0;
    logic        lsb_full_in = 1'b0;
    logic        decoder_inst_en_out;
    logic [31:0] decoder_inst_out;
    logic [31:0] decoder_pc_out;

    inst_queue #(.QUEUE_SIZE(QS)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .rob_flush_in        (rob_flush_in),
        .fetcher_en_in       (fetcher_en_in),
        .fetcher_inst_in     (fetcher_inst_in),
        .fetcher_pc_in       (fetcher_pc_in),
        .fetcher_full_out    (fetcher_full_out),
        .rob_full_in         (rob_full_in),
        .rs_full_in          (rs_full_in),
        .lsb_full_in         (lsb_full_in),
        .decoder_inst_en_out (decoder_inst_en_out),
        .decoder_inst_out    (decoder_inst_out),
        .decoder_pc_out      (decoder_pc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int drops = 0;
    int issues_seen = 0;

    item_t       mq[$];
    item_t       exp_q[$];
    logic        m_en = 1'b0;
    logic [31:0] m_inst = '0;
    logic [31:0] m_pc = '0;
    bit          prev_rdy = 1'b0;
    bit          mon_on = 1'b0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endfunction

    // Reference model: the buffer is a plain queue, issues are appended to exp_q.
    always @(posedge clk_in) begin
        item_t it;
        bit    stall;
        bit    can_push;
        bit    can_pop;
        prev_rdy = rdy_in;
        if (rst_in) begin
            mq.delete();
            m_en = 1'b0;
            m_inst = '0;
            m_pc = '0;
        end else if (rdy_in) begin
            if (rob_flush_in) begin
                mq.delete();
                m_en = 1'b0;
            end else begin
                stall    = rob_full_in | rs_full_in | lsb_full_in;
                can_push = fetcher_en_in && (mq.size() != QS);
                can_pop  = (mq.size() != 0) && !stall;
                if (fetcher_en_in && mq.size() == QS) drops++;
                it.inst = fetcher_inst_in;
                it.pc   = fetcher_pc_in;
`ifdef INSTQUEUE_BYPASS_EN
                if (can_push && mq.size() == 0 && !stall) begin
                    m_en = 1'b1;
                    m_inst = it.inst;
                    m_pc = it.pc;
                    exp_q.push_back(it);
                    can_push = 1'b0;
                end else
`endif
                if (can_pop) begin
                    item_t hd;
                    hd = mq.pop_front();
                    m_en = 1'b1;
                    m_inst = hd.inst;
                    m_pc = hd.pc;
                    exp_q.push_back(hd);
                end else begin
                    m_en = 1'b0;
                end
                if (can_push) mq.push_back(it);
            end
        end
    end

    // Monitor: per-cycle port checks plus scoreboard pop on each fresh issue.
    always @(negedge clk_in) begin
        item_t it;
        if (mon_on) begin
            chk("en", 32'(decoder_inst_en_out), 32'(m_en));
            chk("full", 32'(fetcher_full_out), 32'(mq.size() >= QS - 2));
            chk("inst_hold", decoder_inst_out, m_inst);
            chk("pc_hold", decoder_pc_out, m_pc);
            if (decoder_inst_en_out && prev_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue got pc %h want none", decoder_pc_out);
                end else begin
                    it = exp_q.pop_front();
                    chk("sb_inst", decoder_inst_out, it.inst);
                    chk("sb_pc", decoder_pc_out, it.pc);
                    issues_seen++;
                end
            end
        end
    end

    task automatic cyc(input bit en, input logic [31:0] inst, input logic [31:0] pc);
        fetcher_en_in   = en;
        fetcher_inst_in = inst;
        fetcher_pc_in   = pc;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        mon_on = 1'b1;
        chk("rst_en", 32'(decoder_inst_en_out), 32'd0);
        chk("rst_inst", decoder_inst_out, 32'd0);
        chk("rst_pc", decoder_pc_out, 32'd0);
        chk("rst_full", 32'(fetcher_full_out), 32'd0);
        rst_in = 1'b0;

        // single push
        cyc(1'b1, 32'h00500093, 32'h0);
`ifdef INSTQUEUE_BYPASS_EN
        chk("t1_latency_en", 32'(decoder_inst_en_out), 32'd1);
`else
        chk("t1_latency_en", 32'(decoder_inst_en_out), 32'd0);
        idle(1);
        chk("t1_latency_en2", 32'(decoder_inst_en_out), 32'd1);
`endif
        chk("t1_inst", decoder_inst_out, 32'h00500093);
        idle(4);
        chk("t1_issues", issues_seen, 1);

        // fill to full under stall, 17th push dropped, then drain in order
        rs_full_in = 1'b1;
        d0 = drops;
        for (int i = 0; i < 17; i++) cyc(1'b1, $urandom, 32'(i * 4));
        chk("fill_full", 32'(fetcher_full_out), 32'd1);
        chk("fill_drops", drops - d0, 1);
        rs_full_in = 1'b0;
        idle(20);
        chk("fill_issues", issues_seen, 17);
        chk("fill_last_pc", decoder_pc_out, 32'h3C);

        // move pointers to 15, then stream across the wrap
        rs_full_in = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b1, $urandom, 32'h800 + 32'(i * 4));
        rs_full_in = 1'b0;
        idle(17);
        for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 32'h1000 + 32'(i * 4));
        idle(4);
        chk("wrap_issues", issues_seen, 52);

        // flush with simultaneous push
        rs_full_in = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 32'h2000 + 32'(i * 4));
        rob_flush_in = 1'b1;
        cyc(1'b1, 32'hDEADBEEF, 32'hDEAD0000);
        rob_flush_in = 1'b0;
        rs_full_in = 1'b0;
        chk("flush_en", 32'(decoder_inst_en_out), 32'd0);
        cyc(1'b1, 32'h00A00113, 32'h3000);
        idle(4);
        chk("flush_next_pc", decoder_pc_out, 32'h3000);

        // rdy_in low freezes everything, including a high enable
        rs_full_in = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 32'h4000 + 32'(i * 4));
        rs_full_in = 1'b0;
        idle(1);
        chk("rdy_pre_en", 32'(decoder_inst_en_out), 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 32'h5000 + 32'(i * 4));
        chk("rdy_frozen_en", 32'(decoder_inst_en_out), 32'd1);
        chk("rdy_frozen_pc", decoder_pc_out, 32'h4000);
        rdy_in = 1'b1;
        idle(5);
        chk("rdy_last_pc", decoder_pc_out, 32'h400C);

        // alternating lsb stall
        rs_full_in = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 32'h6000 + 32'(i * 4));
        rs_full_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lsb_full_in = (i % 2 == 0);
            cyc(1'b0, '0, '0);
        end
        lsb_full_in = 1'b0;
        idle(4);
        chk("alt_last_pc", decoder_pc_out, 32'h600C);

        // random traffic with a well-behaved fetcher
        for (int i = 0; i < 400; i++) begin
            rst_in       = ($urandom_range(0, 149) == 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            rob_flush_in = ($urandom_range(0, 29) == 0);
            rob_full_in  = ($urandom_range(0, 5) == 0);
            rs_full_in   = ($urandom_range(0, 5) == 0);
            lsb_full_in  = ($urandom_range(0, 5) == 0);
            cyc((mq.size() < QS - 2) && ($urandom_range(0, 2) != 0), $urandom, $urandom);
        end
        rst_in = 1'b0; rdy_in = 1'b1; rob_flush_in = 1'b0;
        rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0;
        idle(24);
        chk("leftover_expected", exp_q.size(), 0);
        chk("leftover_model", mq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
